return_stack: RTL
=================

# return_stack

Subroutine/interrupt return-address stack for the hotstate microsequencer. It generates the `returnadr` value that the next-address selector consumes on `sub_pop`. It captures return points on calls and interrupt entry, and exposes depth and error status to the control block. It mirrors the next-address selector's priority order, so push/pop only take effect in cycles where the selector actually uses them.

## Interface
- `BUS_WIDTH`, 8: microcode address width.
- `DEPTH`, 8: number of stack entries, ≥2.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ready` input 1: sequencer ready; 0 clears the stack like `rst`.
- `hlt` input 1: halt; freezes all state.
- `address` input BUS_WIDTH: current microcode address.
- `sub_push` input 1: call in current instruction.
- `sub_pop` input 1: return in current instruction.
- `jadr` input 1: jump taken this cycle; suppresses pop.
- `fired` input 1: interrupt entry this cycle.
- `switch_active` input 1: switch dispatch this cycle; suppresses all stack ops.
- `returnadr` output BUS_WIDTH: top-of-stack entry, 0 when empty.
- `depth` output $clog2(DEPTH+1): number of valid entries.
- `empty` output 1: `depth`==0.
- `full` output 1: `depth`==DEPTH.
- `overflow` output 1: sticky, push attempted while full.
- `underflow` output 1: sticky, pop attempted while empty.

## Operation
- Priority per cycle: `rst` > `!ready` > `hlt` > `switch_active` > `fired` > call/return.
- `rst`=1 or `ready`=0 sets `depth`=0, `returnadr`=0, `overflow`=0, `underflow`=0. Memory contents are don't-care.
- `hlt`=1: no change, including sticky flags.
- `switch_active`=1: no push, no pop.
- Interrupt push: `fired`=1 pushes `address` so the preempted instruction re-executes. `sub_push` and `sub_pop` are ignored that cycle.
- Call push: `sub_push`=1 with no higher-priority event pushes `address`+1, modulo 2^BUS_WIDTH (0xFF+1 = 0x00 at width 8).
- Return pop: effective when `sub_pop`=1, `jadr`=0, and no higher-priority event. It removes the top entry.
- Push and pop both effective in one cycle: top entry is replaced by the push value and `depth` is unchanged. This holds even when full, and no overflow is flagged.
- Push and pop both effective while empty: push value is written, `depth`=1, `underflow` set.
- Push while full (no pop): entry discarded, stack unchanged, `overflow` set.
- Pop while empty (no push): stack unchanged, `returnadr` stays 0, `underflow` set.
- Sticky flags clear only on `rst` or `ready`=0.
- LIFO order is exact: returned addresses come out in reverse push order for any interleaving.

## Timing
- `returnadr`, `depth`, `empty`, `full` reflect current state combinationally from registers, with no input-to-output path.
- Pop in cycle N: `returnadr` holds the popped value during N, so the selector samples it at the end-of-N edge. From N+1 it shows the next entry down, or 0.
- Push in cycle N: new top visible on `returnadr` from N+1.
- Flags set at the edge ending the offending cycle and are visible from N+1.
- A push followed by a pop in the very next cycle returns the just-pushed value. Same-cycle replace is visible from N+1.
- Throughput: one operation per cycle, no stalls.

## Test plan
- Calls at `address` 0x10, 0x20, 0x30 on consecutive cycles, then three pops -> `returnadr` reads 0x31, 0x21, 0x11 in the three pop cycles. `depth` goes 3→0, `empty`=1, no flags.
- DEPTH=8: nine calls -> `full`=1 after the 8th. The 9th sets `overflow`=1, `depth` stays 8, and the top is still the 8th value. A push+pop while full replaces the top with no new flag.
- Pop on empty -> `underflow`=1, `returnadr`=0, `depth`=0. `underflow` persists through later pushes until `ready` is pulsed low.
- `fired`=1 with `sub_pop`=1 at `address`=0x42 and depth 1 (top 0x05) -> 0x42 pushed, pop ignored, `depth`=2, `returnadr`=0x42.
- `hlt`=1 with `sub_push`=1, and separately `switch_active`=1 with `sub_pop`=1 -> no state change. `jadr`=1 with `sub_pop`=1 -> no pop.
- Call at `address`=0xFF -> `returnadr`=0x00. Then `rst` asserted mid-sequence at depth 3 -> `depth`=0 and all flags 0 on the next cycle.

Source files
------------

// File: rtl/return_stack.sv
// Return-address stack for the microsequencer: captures call/interrupt return points
// and presents the top entry to the next-address selector.
module return_stack #(
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ready,
    input  logic                         hlt,
    input  logic [BUS_WIDTH-1:0]         address,
    input  logic                         sub_push,
    input  logic                         sub_pop,
    input  logic                         jadr,
    input  logic                         fired,
    input  logic                         switch_active,
    output logic [BUS_WIDTH-1:0]         returnadr,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]        cnt, cnt_next;
    logic                 ovf_q, udf_q, ovf_next, udf_next;
    logic                 active, push_eff, pop_eff, mem_we;
    logic                 is_empty, is_full;
    logic [BUS_WIDTH-1:0] push_val;
    logic [PW-1:0]        top_idx, wr_idx;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DW'(DEPTH));
    assign top_idx  = PW'(cnt - DW'(1));

    // Decode mirrors the next-address selector priority so only used ops move the stack.
    always_comb begin
        active   = !rst && ready && !hlt && !switch_active;
        push_val = fired ? address : address + BUS_WIDTH'(1);
        push_eff = active && (fired || sub_push);
        pop_eff  = active && !fired && sub_pop && !jadr;
        cnt_next = cnt;
        ovf_next = ovf_q;
        udf_next = udf_q;
        mem_we   = 1'b0;
        wr_idx   = PW'(cnt);
        case ({push_eff, pop_eff})
            2'b11: begin
                mem_we = 1'b1;
                if (is_empty) begin
                    wr_idx   = '0;
                    cnt_next = DW'(1);
                    udf_next = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            2'b10: begin
                if (is_full) begin
                    ovf_next = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_idx   = PW'(cnt);
                    cnt_next = cnt + DW'(1);
                end
            end
            2'b01: begin
                if (is_empty) udf_next = 1'b1;
                else          cnt_next = cnt - DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !ready) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            ovf_q <= ovf_next;
            udf_q <= udf_next;
        end
    end

    // Entries above the count are never read, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= push_val;
    end

    assign returnadr = is_empty ? '0 : mem[top_idx];
    assign depth     = cnt;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
